// File: rtl/wb_regfile.sv
// ============================================================================
// Module   : wb_regfile
// Brief    : Writeback stage register plus 32-entry register file with two
//            combinational read ports and a committed-write counter.
//            Optional read bypass of the pending stage entry: REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] rw_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [ADDR_W-1:0] wb_rw_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic [CNT_W-1:0]  commit_cnt_o
);

    localparam logic [ADDR_W-1:0] c_zero_addr = '0;
    localparam logic [CNT_W-1:0]  c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_wb_rw;
    logic              r_wb_wreg;
    logic [DATA_W-1:0] r_wb_wdata;
    logic              r_committed;
    logic [CNT_W-1:0]  r_commit_cnt;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic              w_do_commit;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;

    // The committed flag keeps a stalled entry from being written twice.
    assign w_do_commit = r_wb_wreg && (r_wb_rw != c_zero_addr) && !r_committed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_rw      <= '0;
            r_wb_wreg    <= 1'b0;
            r_wb_wdata   <= '0;
            r_committed  <= 1'b0;
            r_commit_cnt <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_do_commit) begin
                r_regs[r_wb_rw] <= r_wb_wdata;
                r_commit_cnt    <= r_commit_cnt + c_cnt_one;
            end

            if (flush_i) begin
                r_wb_rw     <= '0;
                r_wb_wreg   <= 1'b0;
                r_wb_wdata  <= '0;
                r_committed <= 1'b0;
            end else if (stall_i) begin
                r_committed <= r_committed | w_do_commit;
            end else begin
                r_wb_rw     <= rw_i;
                r_wb_wreg   <= wreg_i;
                r_wb_wdata  <= wdata_i;
                r_committed <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata1 = '0;
        w_rdata2 = '0;
        if (!rst && re1_i && (raddr1_i != c_zero_addr)) begin
`ifdef REGFILE_BYPASS_EN
            if (w_do_commit && (raddr1_i == r_wb_rw)) begin
                w_rdata1 = r_wb_wdata;
            end else begin
                w_rdata1 = r_regs[raddr1_i];
            end
`else
            w_rdata1 = r_regs[raddr1_i];
`endif
        end
        if (!rst && re2_i && (raddr2_i != c_zero_addr)) begin
`ifdef REGFILE_BYPASS_EN
            if (w_do_commit && (raddr2_i == r_wb_rw)) begin
                w_rdata2 = r_wb_wdata;
            end else begin
                w_rdata2 = r_regs[raddr2_i];
            end
`else
            w_rdata2 = r_regs[raddr2_i];
`endif
        end
    end

    assign rdata1_o     = w_rdata1;
    assign rdata2_o     = w_rdata2;
    assign wb_rw_o      = r_wb_rw;
    assign wb_wreg_o    = r_wb_wreg;
    assign wb_wdata_o   = r_wb_wdata;
    assign commit_cnt_o = r_commit_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module   : tb_wb_regfile
// Brief    : Directed self-checking bench for wb_regfile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i;
    logic [4:0]  rw_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        re1_i, re2_i;
    logic [4:0]  raddr1_i, raddr2_i;
    logic [31:0] rdata1_o, rdata2_o;
    logic [4:0]  wb_rw_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wdata_o;
    logic [31:0] commit_cnt_o;

    int n_checks = 0;
    int n_fails  = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    wb_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .rw_i         (rw_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .re1_i        (re1_i),
        .raddr1_i     (raddr1_i),
        .rdata1_o     (rdata1_o),
        .re2_i        (re2_i),
        .raddr2_i     (raddr2_i),
        .rdata2_o     (rdata2_o),
        .wb_rw_o      (wb_rw_o),
        .wb_wreg_o    (wb_wreg_o),
        .wb_wdata_o   (wb_wdata_o),
        .commit_cnt_o (commit_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rw, input logic we, input logic [31:0] wd);
        rw_i    = rw;
        wreg_i  = we;
        wdata_i = wd;
    endtask

    task automatic rd1(input logic [4:0] a);
        re1_i    = 1'b1;
        raddr1_i = a;
        #1;
    endtask

    initial begin
        logic [31:0] acc;
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        drive(5'd0, 1'b0, 32'h0);
        re1_i = 1'b0; re2_i = 1'b0; raddr1_i = '0; raddr2_i = '0;

        // 1: reset
        tick();
        check("rst_wb_rw", {27'd0, wb_rw_o}, 32'd0);
        check("rst_wb_wreg", {31'd0, wb_wreg_o}, 32'd0);
        check("rst_wb_wdata", wb_wdata_o, 32'd0);
        check("rst_cnt", commit_cnt_o, 32'd0);
        rst = 1'b0;
        acc = 32'd0;
        for (int i = 1; i < 32; i++) begin
            rd1(5'(i));
            acc = acc | rdata1_o;
        end
        check("rst_regs_or", acc, 32'd0);

        // 2: basic write, latency
        drive(5'd5, 1'b1, 32'h1234_5678);
        tick();
        drive(5'd0, 1'b0, 32'h0);
        check("t2_wb_rw", {27'd0, wb_rw_o}, 32'd5);
        check("t2_wb_wreg", {31'd0, wb_wreg_o}, 32'd1);
        check("t2_wb_wdata", wb_wdata_o, 32'h1234_5678);
        rd1(5'd5);
        check("t2_r5_edge1", rdata1_o, c_byp ? 32'h1234_5678 : 32'h0);
        tick();
        check("t2_r5_edge2", rdata1_o, 32'h1234_5678);
        check("t2_cnt", commit_cnt_o, 32'd1);

        // 3: r0 write ignored
        drive(5'd0, 1'b1, 32'hFFFF_FFFF);
        tick();
        drive(5'd0, 1'b0, 32'h0);
        tick();
        rd1(5'd0);
        check("t3_r0", rdata1_o, 32'd0);
        check("t3_cnt", commit_cnt_o, 32'd1);

        // 4: stall holds entry, single write; flush with stall inserts bubble
        drive(5'd7, 1'b1, 32'h0000_A5A5);
        tick();
        drive(5'd0, 1'b0, 32'h0);
        stall_i = 1'b1;
        tick(); tick(); tick();
        check("t4_wb_rw_held", {27'd0, wb_rw_o}, 32'd7);
        check("t4_cnt", commit_cnt_o, 32'd2);
        rd1(5'd7);
        check("t4_r7", rdata1_o, 32'h0000_A5A5);
        flush_i = 1'b1;
        drive(5'd8, 1'b1, 32'hDEAD_BEEF);
        tick();
        check("t4_flush_wreg", {31'd0, wb_wreg_o}, 32'd0);
        check("t4_flush_rw", {27'd0, wb_rw_o}, 32'd0);
        flush_i = 1'b0; stall_i = 1'b0;
        drive(5'd0, 1'b0, 32'h0);
        tick();
        rd1(5'd8);
        check("t4_r8", rdata1_o, 32'd0);
        check("t4_cnt_after", commit_cnt_o, 32'd2);

        // 5: reset discards pending entry
        drive(5'd9, 1'b1, 32'h1);
        tick();
        drive(5'd0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd1(5'd9);
        check("t5_r9", rdata1_o, 32'd0);
        rd1(5'd5);
        check("t5_r5_cleared", rdata1_o, 32'd0);
        check("t5_cnt", commit_cnt_o, 32'd0);

        // 6: back-to-back writes with both ports reading
        re1_i = 1'b1; raddr1_i = 5'd3;
        re2_i = 1'b1; raddr2_i = 5'd4;
        drive(5'd3, 1'b1, 32'd1);
        tick();
        drive(5'd3, 1'b1, 32'd2);
        check("t6_c1_r3", rdata1_o, c_byp ? 32'd1 : 32'd0);
        check("t6_c1_r4", rdata2_o, 32'd0);
        tick();
        drive(5'd4, 1'b1, 32'd3);
        check("t6_c2_r3", rdata1_o, c_byp ? 32'd2 : 32'd1);
        check("t6_c2_r4", rdata2_o, 32'd0);
        tick();
        drive(5'd0, 1'b0, 32'd0);
        check("t6_c3_r3", rdata1_o, 32'd2);
        check("t6_c3_r4", rdata2_o, c_byp ? 32'd3 : 32'd0);
        tick();
        check("t6_final_r3", rdata1_o, 32'd2);
        check("t6_final_r4", rdata2_o, 32'd3);
        check("t6_cnt", commit_cnt_o, 32'd3);

        // Disabled read port returns zero even for a written register
        re2_i = 1'b0;
        #1;
        check("re2_off", rdata2_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
